// File: rtl/msrv32_pipe_ctrl_if.sv
// Control bundle between the stage-2 pipeline sequencer and the core datapath.
// The core side drives hazard/memory status; the sequencer drives register controls.
interface msrv32_pipe_ctrl_if;
   logic        branch_taken_in;
   logic        trap_taken_in;
   logic        mem_op_in;
   logic        dmem_ack_in;
   logic        stage2_en_out;
   logic        stage2_flush_out;
   logic        pc_hold_out;
   logic        wr_kill_out;
   logic        bus_err_out;
   logic        trap_ack_out;
   logic [1:0]  state_out;
   logic [31:0] perf_stall_cnt_out;
   logic [31:0] perf_flush_cnt_out;

   modport master (
      output branch_taken_in, trap_taken_in, mem_op_in, dmem_ack_in,
      input  stage2_en_out, stage2_flush_out, pc_hold_out, wr_kill_out,
      input  bus_err_out, trap_ack_out, state_out,
      input  perf_stall_cnt_out, perf_flush_cnt_out
   );

   modport slave (
      input  branch_taken_in, trap_taken_in, mem_op_in, dmem_ack_in,
      output stage2_en_out, stage2_flush_out, pc_hold_out, wr_kill_out,
      output bus_err_out, trap_ack_out, state_out,
      output perf_stall_cnt_out, perf_flush_cnt_out
   );
endinterface

// File: rtl/msrv32_pipe_ctrl.sv
// Stage-2 pipeline sequencer: memory stalls, branch/trap bubbles, dmem timeout to bus error.
// Define MSRV32_PIPE_PERF_EN to build the stall/flush performance counters.
module msrv32_pipe_ctrl #(
   parameter int MAX_WAIT     = 15,
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 4
) (
   input logic              clk_in,
   input logic              reset_in,
   msrv32_pipe_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      FLUSH    = 2'd2,
      TRAP     = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(MAX_WAIT - 1);
   localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   state_t           r_state;
   state_t           w_state_next;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_next;

   logic w_en;
   logic w_flush;
   logic w_hold;
   logic w_kill;
   logic w_bus_err;
   logic w_trap_ack;

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         r_state <= RUN;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_en         = 1'b0;
      w_flush      = 1'b0;
      w_hold       = 1'b0;
      w_kill       = 1'b0;
      w_bus_err    = 1'b0;
      w_trap_ack   = 1'b0;

      unique case (r_state)
         RUN: begin
            if (bus.trap_taken_in) begin
               w_trap_ack   = 1'b1;
               w_flush      = 1'b1;
               w_kill       = 1'b1;
               w_en         = 1'b1;
               w_state_next = TRAP;
               w_cnt_next   = '0;
            end else if (bus.mem_op_in && !bus.dmem_ack_in) begin
               // The stalled RUN cycle is the first wait cycle, so the counter starts at 1.
               w_hold       = 1'b1;
               w_state_next = MEM_WAIT;
               w_cnt_next   = CNT_ONE;
            end else if (bus.branch_taken_in) begin
               w_en         = 1'b1;
               w_flush      = 1'b1;
               w_state_next = FLUSH;
               w_cnt_next   = '0;
            end else begin
               w_en = 1'b1;
            end
         end

         MEM_WAIT: begin
            w_hold = 1'b1;
            if (bus.dmem_ack_in) begin
               w_en         = 1'b1;
               w_hold       = 1'b0;
               w_state_next = RUN;
               w_cnt_next   = '0;
            end else if (r_cnt == WAIT_LAST) begin
               w_bus_err    = 1'b1;
               w_kill       = 1'b1;
               w_flush      = 1'b1;
               w_en         = 1'b1;
               w_state_next = TRAP;
               w_cnt_next   = '0;
            end else begin
               // A pending trap stays asserted by its source until we are back in RUN.
               w_cnt_next = r_cnt + CNT_ONE;
            end
         end

         FLUSH: begin
            w_en    = 1'b1;
            w_flush = 1'b1;
            w_kill  = 1'b1;
            if (bus.trap_taken_in) begin
               w_trap_ack   = 1'b1;
               w_state_next = TRAP;
               w_cnt_next   = '0;
            end else if (r_cnt == FLUSH_LAST) begin
               w_state_next = RUN;
               w_cnt_next   = '0;
            end else begin
               w_cnt_next = r_cnt + CNT_ONE;
            end
         end

         TRAP: begin
            w_en         = 1'b1;
            w_flush      = 1'b1;
            w_kill       = 1'b1;
            w_state_next = FLUSH;
            w_cnt_next   = '0;
         end

         default: begin
            w_state_next = RUN;
            w_cnt_next   = '0;
         end
      endcase

      // Reset overrides the decode so stage 2 is bubbled and PC frozen whatever the state.
      if (reset_in) begin
         w_en       = 1'b0;
         w_flush    = 1'b1;
         w_hold     = 1'b1;
         w_kill     = 1'b1;
         w_bus_err  = 1'b0;
         w_trap_ack = 1'b0;
      end
   end

   assign bus.stage2_en_out    = w_en;
   assign bus.stage2_flush_out = w_flush;
   assign bus.pc_hold_out      = w_hold;
   assign bus.wr_kill_out      = w_kill;
   assign bus.bus_err_out      = w_bus_err;
   assign bus.trap_ack_out     = w_trap_ack;
   assign bus.state_out        = r_state;

`ifdef MSRV32_PIPE_PERF_EN
   logic [31:0] r_perf_stall;
   logic [31:0] r_perf_flush;

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         r_perf_stall <= 32'd0;
         r_perf_flush <= 32'd0;
      end else begin
         if (w_hold) begin
            r_perf_stall <= r_perf_stall + 32'd1;
         end
         if (w_flush) begin
            r_perf_flush <= r_perf_flush + 32'd1;
         end
      end
   end

   assign bus.perf_stall_cnt_out = r_perf_stall;
   assign bus.perf_flush_cnt_out = r_perf_flush;
`else
   assign bus.perf_stall_cnt_out = 32'd0;
   assign bus.perf_flush_cnt_out = 32'd0;
`endif

endmodule

// File: tb/tb_msrv32_pipe_ctrl.sv
// Scoreboard bench for msrv32_pipe_ctrl: directed scenarios then random traffic,
// checked every cycle against a stall/bubble-count reference model.
module tb_msrv32_pipe_ctrl;

   localparam int MAXW = 6;
   localparam int FLC  = 2;

   localparam int M_RUN   = 0;
   localparam int M_WAIT  = 1;
   localparam int M_FLUSH = 2;
   localparam int M_TRAP  = 3;

   typedef struct packed {
      logic [1:0]  state;
      logic        en;
      logic        flush;
      logic        hold;
      logic        kill;
      logic        bus_err;
      logic        trap_ack;
      logic [31:0] pstall;
      logic [31:0] pflush;
   } obs_t;

   logic clk_in;
   logic reset_in;

   msrv32_pipe_ctrl_if u_if ();

   msrv32_pipe_ctrl #(
      .MAX_WAIT     (MAXW),
      .FLUSH_CYCLES (FLC),
      .CNT_W        (4)
   ) u_dut (
      .clk_in   (clk_in),
      .reset_in (reset_in),
      .bus      (u_if)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   obs_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;

   // Reference model: mode, number of stalled cycles so far, bubbles still owed.
   int          m_mode       = M_RUN;
   int          m_stalled    = 0;
   int          m_flush_left = 0;
   logic [31:0] m_pstall     = 32'd0;
   logic [31:0] m_pflush     = 32'd0;

   task automatic model_step(input logic rst, input logic br, input logic tr,
                             input logic mem, input logic ack);
      obs_t e;
      e = '0;
      e.state = 2'(m_mode);
`ifdef MSRV32_PIPE_PERF_EN
      e.pstall = m_pstall;
      e.pflush = m_pflush;
`endif
      if (rst) begin
         e.flush = 1'b1;
         e.hold  = 1'b1;
         e.kill  = 1'b1;
         m_mode    = M_RUN;
         m_stalled = 0;
      end else begin
         case (m_mode)
            M_RUN: begin
               if (tr) begin
                  e.trap_ack = 1'b1; e.flush = 1'b1; e.kill = 1'b1; e.en = 1'b1;
                  m_mode = M_TRAP;
               end else if (mem && !ack) begin
                  e.hold = 1'b1;
                  m_stalled = 1;
                  m_mode = M_WAIT;
               end else if (br) begin
                  e.en = 1'b1; e.flush = 1'b1;
                  m_flush_left = FLC;
                  m_mode = M_FLUSH;
               end else begin
                  e.en = 1'b1;
               end
            end
            M_WAIT: begin
               if (ack) begin
                  e.en = 1'b1;
                  m_mode = M_RUN;
               end else if (m_stalled + 1 == MAXW) begin
                  e.hold = 1'b1; e.bus_err = 1'b1; e.kill = 1'b1;
                  e.flush = 1'b1; e.en = 1'b1;
                  m_mode = M_TRAP;
               end else begin
                  e.hold = 1'b1;
                  m_stalled++;
               end
            end
            M_FLUSH: begin
               e.en = 1'b1; e.flush = 1'b1; e.kill = 1'b1;
               if (tr) begin
                  e.trap_ack = 1'b1;
                  m_mode = M_TRAP;
               end else begin
                  m_flush_left--;
                  if (m_flush_left == 0) m_mode = M_RUN;
               end
            end
            default: begin
               e.en = 1'b1; e.flush = 1'b1; e.kill = 1'b1;
               m_flush_left = FLC;
               m_mode = M_FLUSH;
            end
         endcase
         if (e.hold)  m_pstall = m_pstall + 32'd1;
         if (e.flush) m_pflush = m_pflush + 32'd1;
      end
      if (rst) begin
         m_pstall = 32'd0;
         m_pflush = 32'd0;
      end
      exp_q.push_back(e);
   endtask

   task automatic drive(input logic rst, input logic br, input logic tr,
                        input logic mem, input logic ack);
      @(posedge clk_in);
      #1;
      reset_in               = rst;
      u_if.branch_taken_in   = br;
      u_if.trap_taken_in     = tr;
      u_if.mem_op_in         = mem;
      u_if.dmem_ack_in       = ack;
      model_step(rst, br, tr, mem, ack);
   endtask

   // Monitor: one comparison per cycle of every output against the queued expectation.
   initial begin : monitor
      obs_t e;
      obs_t a;
      forever begin
         @(negedge clk_in);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a.state    = u_if.state_out;
            a.en       = u_if.stage2_en_out;
            a.flush    = u_if.stage2_flush_out;
            a.hold     = u_if.pc_hold_out;
            a.kill     = u_if.wr_kill_out;
            a.bus_err  = u_if.bus_err_out;
            a.trap_ack = u_if.trap_ack_out;
            a.pstall   = u_if.perf_stall_cnt_out;
            a.pflush   = u_if.perf_flush_cnt_out;
            n_checks++;
            if (a === e) begin
               n_pass++;
            end else begin
               $display("FAIL cycle_outputs cyc=%0d got st=%0d en=%b fl=%b hold=%b kill=%b berr=%b tack=%b ps=%0d pf=%0d want st=%0d en=%b fl=%b hold=%b kill=%b berr=%b tack=%b ps=%0d pf=%0d",
                        cyc, a.state, a.en, a.flush, a.hold, a.kill, a.bus_err, a.trap_ack,
                        a.pstall, a.pflush, e.state, e.en, e.flush, e.hold, e.kill,
                        e.bus_err, e.trap_ack, e.pstall, e.pflush);
            end
            $display("cyc=%0d rst=%b br=%b tr=%b mem=%b ack=%b -> st=%0d en=%b fl=%b hold=%b kill=%b berr=%b tack=%b",
                     cyc, reset_in, u_if.branch_taken_in, u_if.trap_taken_in, u_if.mem_op_in,
                     u_if.dmem_ack_in, a.state, a.en, a.flush, a.hold, a.kill, a.bus_err,
                     a.trap_ack);
            cyc++;
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog run did not complete within time budget");
      $display("%0d/%0d checks passed", n_pass, n_checks + 1);
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      int wait_guard;
      reset_in             = 1'b1;
      u_if.branch_taken_in = 1'b0;
      u_if.trap_taken_in   = 1'b0;
      u_if.mem_op_in       = 1'b0;
      u_if.dmem_ack_in     = 1'b0;
      repeat (2) @(posedge clk_in);

      // Reset held 3 cycles, then idle.
      repeat (3) drive(1, 0, 0, 0, 0);
      repeat (2) drive(0, 0, 0, 0, 0);
      // Four stalled cycles then ack.
      repeat (4) drive(0, 0, 0, 1, 0);
      drive(0, 0, 0, 1, 1);
      drive(0, 0, 0, 0, 0);
      // Timeout with no ack, then drain.
      repeat (MAXW) drive(0, 0, 0, 1, 0);
      repeat (5) drive(0, 0, 0, 0, 0);
      // Single branch.
      drive(0, 1, 0, 0, 0);
      repeat (4) drive(0, 0, 0, 0, 0);
      // Trap and branch together.
      drive(0, 1, 1, 0, 0);
      repeat (4) drive(0, 0, 0, 0, 0);
      // Ack arriving on the timeout cycle.
      repeat (MAXW - 1) drive(0, 0, 0, 1, 0);
      drive(0, 0, 0, 1, 1);
      repeat (2) drive(0, 0, 0, 0, 0);
      // Reset in the middle of a memory wait.
      repeat (3) drive(0, 0, 0, 1, 0);
      drive(1, 0, 0, 1, 0);
      repeat (MAXW + 2) drive(0, 0, 0, 0, 0);
      // Trap arriving during a flush.
      drive(0, 1, 0, 0, 0);
      drive(0, 0, 1, 0, 0);
      repeat (5) drive(0, 0, 0, 0, 0);

      for (int i = 0; i < 3000; i++) begin
         drive(($urandom_range(0, 63) == 0),
               ($urandom_range(0, 5) == 0),
               ($urandom_range(0, 9) == 0),
               ($urandom_range(0, 2) == 0),
               ($urandom_range(0, 2) == 0));
      end
      drive(0, 0, 0, 0, 0);

      wait_guard = 0;
      while (exp_q.size() != 0 && wait_guard < 10) begin
         @(posedge clk_in);
         wait_guard++;
      end
      if (exp_q.size() != 0) begin
         n_checks++;
         $display("FAIL drain got %0d pending expectations want 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
